clk_gen_diff: RTL and testbench

CLK_GEN_DIFF -- requirements
Module: clk_gen_diff

---
 rtl/clk_gen_diff_pkg.sv | 12 +
 rtl/diff_obuf.sv | 11 +
 rtl/clk_gen_diff.sv | 108 ++++++++++
 tb/tb_clk_gen_diff.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/clk_gen_diff_pkg.sv
// Shared definitions for the differential clock generator: FSM encoding and default widths.
package clk_gen_diff_pkg;

  localparam int unsigned DefDivW = 16;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StStop = 2'd2
  } state_e;

endpackage

// File: rtl/diff_obuf.sv
// Differential output buffer wrapper; behavioural stand-in for the OBUFDS primitive (I -> O/OB).
module diff_obuf (
  input  logic i,
  output logic o,
  output logic ob
);

  assign o  = i;
  assign ob = ~i;

endmodule

// File: rtl/clk_gen_diff.sv
// Programmable clock divider on clk200m with glitch-free enable/stop and handshaked divide updates.
module clk_gen_diff
  import clk_gen_diff_pkg::*;
#(
  parameter int unsigned DIV_W   = DefDivW,
  parameter int unsigned DEF_DIV = 0
) (
  input  logic             clk200m,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] div_cfg,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  output logic             clk_se,
  output logic             clk_outP,
  output logic             clk_outN,
  output logic             running,
  output logic [31:0]      edge_cnt
);

  state_e           state_q;
  logic [DIV_W-1:0] hc_q;
  logic [DIV_W-1:0] active_div_q;
  logic [DIV_W-1:0] shadow_q;
  logic             pending_q;
  logic             clk_se_q;
  logic [31:0]      edge_cnt_q;
  logic             hc_done;

  assign hc_done = (hc_q == active_div_q);

  always_ff @(posedge clk200m or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      hc_q         <= '0;
      active_div_q <= DIV_W'(DEF_DIV);
      shadow_q     <= '0;
      pending_q    <= 1'b0;
      clk_se_q     <= 1'b0;
      edge_cnt_q   <= '0;
    end else begin
      // Acceptance only when nothing is pending, so it never collides with an apply.
      if (cfg_valid && !pending_q) begin
        shadow_q  <= div_cfg;
        pending_q <= 1'b1;
      end

      case (state_q)
        StIdle: begin
          clk_se_q <= 1'b0;
          hc_q     <= '0;
          if (pending_q) begin
            active_div_q <= shadow_q;
            pending_q    <= 1'b0;
          end
          if (en) begin
            state_q <= StRun;
          end
        end

        StRun, StStop: begin
          if (state_q == StRun && !en && !clk_se_q) begin
            // Low phase may be cut short; the next rising edge is simply never produced.
            state_q <= StIdle;
            hc_q    <= '0;
          end else if (hc_done) begin
            hc_q     <= '0;
            clk_se_q <= ~clk_se_q;
            if (clk_se_q) begin
              // Falling toggle: safe point to switch divide and to finish a stop.
              if (pending_q) begin
                active_div_q <= shadow_q;
                pending_q    <= 1'b0;
              end
              if (state_q == StStop || !en) begin
                state_q <= StIdle;
              end
            end else begin
              edge_cnt_q <= edge_cnt_q + 32'd1;
            end
          end else begin
            hc_q <= hc_q + DIV_W'(1);
            // Only reachable from RUN with clk_se high: finish the high phase first.
            if (!en) begin
              state_q <= StStop;
            end
          end
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign cfg_ready = ~pending_q;
  assign clk_se    = clk_se_q;
  assign running   = (state_q != StIdle);
  assign edge_cnt  = edge_cnt_q;

  diff_obuf u_diff_obuf (
    .i  (clk_se_q),
    .o  (clk_outP),
    .ob (clk_outN)
  );

endmodule

// File: tb/tb_clk_gen_diff.sv
// Directed self-checking bench for clk_gen_diff: divide, stop, config handshake, reset, wrap.
module tb_clk_gen_diff;

  logic        clk200m;
  logic        rst;
  logic        en;
  logic [15:0] div_cfg;
  logic        cfg_valid;
  logic        cfg_ready;
  logic        clk_se;
  logic        clk_outP;
  logic        clk_outN;
  logic        running;
  logic [31:0] edge_cnt;

  int checks = 0;
  int errors = 0;

  clk_gen_diff dut (
    .clk200m   (clk200m),
    .rst       (rst),
    .en        (en),
    .div_cfg   (div_cfg),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .clk_se    (clk_se),
    .clk_outP  (clk_outP),
    .clk_outN  (clk_outN),
    .running   (running),
    .edge_cnt  (edge_cnt)
  );

  initial clk200m = 1'b0;
  always #5 clk200m = ~clk200m;

  task automatic tick();
    @(posedge clk200m);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; en = 1'b0; div_cfg = '0; cfg_valid = 1'b0;
    #1;
    check("rst_clk_se",    32'(clk_se), 32'd0);
    check("rst_outP",      32'(clk_outP), 32'd0);
    check("rst_outN",      32'(clk_outN), 32'd1);
    check("rst_running",   32'(running), 32'd0);
    check("rst_edge_cnt",  edge_cnt, 32'd0);
    check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    tick(); tick();
    rst = 1'b0;

    // div=0: running next cycle, toggle every cycle.
    en = 1'b1;
    tick();
    check("div0_running", 32'(running), 32'd1);
    check("div0_first_low", 32'(clk_se), 32'd0);
    for (int i = 0; i < 9; i++) begin
      tick();
      check("div0_toggle", 32'(clk_se), (i % 2 == 0) ? 32'd1 : 32'd0);
    end
    check("div0_edge_cnt5", edge_cnt, 32'd5);

    // Send div 4 while high: applied on the second falling toggle from now.
    cfg_valid = 1'b1; div_cfg = 16'd4;
    tick();
    cfg_valid = 1'b0;
    check("cfg4_fall", 32'(clk_se), 32'd0);
    check("cfg4_not_ready", 32'(cfg_ready), 32'd0);
    tick();
    check("cfg4_rise_old", 32'(clk_se), 32'd1);
    check("cfg4_still_pending", 32'(cfg_ready), 32'd0);
    tick();
    check("cfg4_apply_fall", 32'(clk_se), 32'd0);
    check("cfg4_ready_again", 32'(cfg_ready), 32'd1);
    for (int j = 0; j < 10; j++) begin
      tick();
      check("div4_wave", 32'(clk_se), (j >= 4 && j <= 8) ? 32'd1 : 32'd0);
    end
    check("div4_edge_cnt", edge_cnt, 32'd7);

    // Drop en while low: idle next cycle, no more edges.
    en = 1'b0;
    tick();
    check("stop_low_running", 32'(running), 32'd0);
    tick();
    check("stop_low_clk", 32'(clk_se), 32'd0);
    check("stop_low_edges", edge_cnt, 32'd7);

    // Config in IDLE: applied the cycle after acceptance.
    cfg_valid = 1'b1; div_cfg = 16'd7;
    tick();
    cfg_valid = 1'b0;
    check("idle_cfg_not_ready", 32'(cfg_ready), 32'd0);
    tick();
    check("idle_cfg_ready", 32'(cfg_ready), 32'd1);
    check("idle_cfg_active", 32'(dut.active_div_q), 32'd7);
    en = 1'b1;
    tick();
    check("div7_entry_running", 32'(running), 32'd1);
    for (int k = 1; k <= 8; k++) begin
      tick();
      check("div7_first_rise", 32'(clk_se), (k == 8) ? 32'd1 : 32'd0);
    end
    check("div7_edge_cnt", edge_cnt, 32'd8);

    // Send div 9 mid-high; it lands on the following fall.
    cfg_valid = 1'b1; div_cfg = 16'd9;
    tick();
    cfg_valid = 1'b0;
    check("cfg9_not_ready", 32'(cfg_ready), 32'd0);
    for (int n = 1; n <= 17; n++) begin
      tick();
      check("div9_wave", 32'(clk_se), (n <= 6) ? 32'd1 : ((n <= 16) ? 32'd0 : 32'd1));
    end
    check("div9_edge_cnt", edge_cnt, 32'd9);

    // Drop en 3 cycles into high; re-raise during STOP; high still lasts 10 cycles.
    tick(); tick();
    en = 1'b0;
    for (int m = 0; m < 4; m++) begin
      tick();
      check("stop_high_clk", 32'(clk_se), 32'd1);
      check("stop_high_running", 32'(running), 32'd1);
    end
    en = 1'b1;
    for (int m = 0; m < 3; m++) begin
      tick();
      check("stop_reen_clk", 32'(clk_se), 32'd1);
    end
    tick();
    check("stop_fall_clk", 32'(clk_se), 32'd0);
    check("stop_fall_running", 32'(running), 32'd0);
    check("stop_fall_edges", edge_cnt, 32'd9);
    tick();
    check("restart_running", 32'(running), 32'd1);
    check("restart_clk", 32'(clk_se), 32'd0);
    en = 1'b0;
    tick();
    check("idle_again", 32'(running), 32'd0);

    // div 3, then async reset mid-high.
    cfg_valid = 1'b1; div_cfg = 16'd3;
    tick();
    cfg_valid = 1'b0;
    tick();
    en = 1'b1;
    tick();
    for (int p = 0; p < 3; p++) begin
      tick();
      check("div3_low", 32'(clk_se), 32'd0);
    end
    tick();
    check("div3_outP_high", 32'(clk_outP), 32'd1);
    check("div3_outN_low", 32'(clk_outN), 32'd0);
    check("div3_edge_cnt", edge_cnt, 32'd10);
    tick();
    #2;
    rst = 1'b1;
    #1;
    check("arst_outP", 32'(clk_outP), 32'd0);
    check("arst_outN", 32'(clk_outN), 32'd1);
    check("arst_edge_cnt", edge_cnt, 32'd0);
    check("arst_cfg_ready", 32'(cfg_ready), 32'd1);
    check("arst_running", 32'(running), 32'd0);
    tick();
    rst = 1'b0;
    check("arst_held_running", 32'(running), 32'd0);
    tick();
    check("post_rst_running", 32'(running), 32'd1);
    check("post_rst_clk", 32'(clk_se), 32'd0);
    tick();
    check("post_rst_defdiv_rise", 32'(clk_se), 32'd1);
    check("post_rst_edge_cnt", edge_cnt, 32'd1);

    // Edge counter wrap.
    force dut.edge_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.edge_cnt_q;
    tick();
    check("wrap_hold", edge_cnt, 32'hFFFF_FFFF);
    tick();
    check("wrap_zero", edge_cnt, 32'd0);

    // div_cfg change without handshake is ignored.
    div_cfg = 16'd5;
    tick();
    check("nohs_low", 32'(clk_se), 32'd0);
    tick();
    check("nohs_high", 32'(clk_se), 32'd1);
    check("nohs_edge_cnt", edge_cnt, 32'd1);
    check("nohs_ready", 32'(cfg_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
